memory_stage_unit: RTL

//  Memory stage sitting directly downstream of the execute->memory pipe register; consumes its outputs
//  (ALU result, store data, rd, memRead/memWrite/regWrite, instruction). Issues load/store requests to a

---
 rtl/memory_stage_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/memory_stage_unit.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage_unit
// Description : Memory pipeline stage with a valid/ready data-memory interface.
//               It aligns and extends load data and stalls the pipeline until
//               each access completes. Optional macro: MEMORY_MISALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   ALU_result_memory,
    input  logic [DATA_WIDTH-1:0]   store_data_memory,
    input  logic [4:0]              rd_memory,
    input  logic                    memRead_memory,
    input  logic                    memWrite_memory,
    input  logic                    regWrite_memory,
    input  logic [DATA_WIDTH-1:0]   instruction_memory,
    output logic                    dmem_req_valid,
    input  logic                    dmem_req_ready,
    output logic                    dmem_req_write,
    output logic [ADDRESS_BITS-1:0] dmem_req_addr,
    output logic [DATA_WIDTH-1:0]   dmem_req_wdata,
    output logic [3:0]              dmem_req_byte_en,
    input  logic                    dmem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   dmem_resp_rdata,
    output logic                    mem_stall,
    output logic [DATA_WIDTH-1:0]   ALU_result_writeback,
    output logic [DATA_WIDTH-1:0]   load_data_writeback,
    output logic [4:0]              rd_writeback,
    output logic                    memRead_writeback,
    output logic                    regWrite_writeback,
    output logic [DATA_WIDTH-1:0]   instruction_writeback
`ifdef MEMORY_MISALIGN_CHECK_EN
    ,
    output logic                    misaligned_fault_writeback
`endif
);

    localparam logic [6:0]            c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0]            c_OP_STORE  = 7'b0100011;
    localparam logic [DATA_WIDTH-1:0] c_NOP       = 32'h0000_0013;
    localparam logic [0:0]            c_IDLE      = 1'b0;
    localparam logic [0:0]            c_WAIT_RESP = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [1:0]  w_lane;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_access_byte;
    logic        w_access_half;
    logic        w_misaligned;
    logic        w_issue_load;
    logic        w_issue_store;
    logic        w_complete;
    logic        w_load_done;
    logic [7:0]  w_rbyte;
    logic [15:0] w_rhalf;
    logic [DATA_WIDTH-1:0] w_load_ext;

    assign w_opcode   = instruction_memory[6:0];
    assign w_funct3   = instruction_memory[14:12];
    assign w_lane     = ALU_result_memory[1:0];
    assign w_is_load  = memRead_memory  && (w_opcode == c_OP_LOAD);
    assign w_is_store = memWrite_memory && (w_opcode == c_OP_STORE);

    // Stores only know 000/001 as narrow sizes; loads also have the unsigned 1xx forms.
    assign w_access_byte = w_is_store ? (w_funct3 == 3'b000) : (w_funct3[1:0] == 2'b00);
    assign w_access_half = w_is_store ? (w_funct3 == 3'b001) : (w_funct3[1:0] == 2'b01);

`ifdef MEMORY_MISALIGN_CHECK_EN
    assign w_misaligned = (w_is_load || w_is_store) &&
                          ((w_access_half && w_lane[0]) ||
                           (!w_access_byte && !w_access_half && (w_lane != 2'b00)));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_issue_load  = w_is_load  && !w_misaligned;
    assign w_issue_store = w_is_store && !w_misaligned;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:      if (w_issue_load && dmem_req_ready) w_state_next = c_WAIT_RESP;
            c_WAIT_RESP: if (dmem_resp_valid)                w_state_next = c_IDLE;
            default:     w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        dmem_req_valid = 1'b0;
        w_complete     = 1'b0;
        w_load_done    = 1'b0;
        mem_stall      = 1'b0;
        case (r_state)
            c_IDLE: begin
                dmem_req_valid = w_issue_load || w_issue_store;
                w_complete     = w_issue_store && dmem_req_ready;
                mem_stall      = (w_issue_load || w_issue_store) && !w_complete;
            end
            c_WAIT_RESP: begin
                w_complete  = dmem_resp_valid;
                w_load_done = dmem_resp_valid;
                mem_stall   = !dmem_resp_valid;
            end
            default: ;
        endcase
    end

    assign dmem_req_write = w_issue_store;
    assign dmem_req_addr  = ALU_result_memory[ADDRESS_BITS-1:0];

    always_comb begin
        dmem_req_byte_en = 4'b0000;
        dmem_req_wdata   = store_data_memory;
        if (w_issue_store) begin
            if (w_access_byte) begin
                dmem_req_byte_en = 4'b0001 << w_lane;
                dmem_req_wdata   = {4{store_data_memory[7:0]}};
            end else if (w_access_half) begin
                dmem_req_byte_en = 4'b0011 << {w_lane[1], 1'b0};
                dmem_req_wdata   = {2{store_data_memory[15:0]}};
            end else begin
                dmem_req_byte_en = 4'b1111;
            end
        end
    end

    // Response carries the whole word containing the address; pick the lane here.
    assign w_rbyte = dmem_resp_rdata[{w_lane, 3'b000} +: 8];
    assign w_rhalf = dmem_resp_rdata[{w_lane[1], 4'b0000} +: 16];

    always_comb begin
        case (w_funct3)
            3'b000:  w_load_ext = {{24{w_rbyte[7]}}, w_rbyte};
            3'b001:  w_load_ext = {{16{w_rhalf[15]}}, w_rhalf};
            3'b100:  w_load_ext = {24'd0, w_rbyte};
            3'b101:  w_load_ext = {16'd0, w_rhalf};
            default: w_load_ext = dmem_resp_rdata;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || mem_stall) begin
            ALU_result_writeback  <= '0;
            load_data_writeback   <= '0;
            rd_writeback          <= 5'd0;
            memRead_writeback     <= 1'b0;
            regWrite_writeback    <= 1'b0;
            instruction_writeback <= c_NOP;
        end else begin
            ALU_result_writeback  <= ALU_result_memory;
            load_data_writeback   <= w_load_done ? w_load_ext : '0;
            rd_writeback          <= rd_memory;
            memRead_writeback     <= memRead_memory;
            regWrite_writeback    <= regWrite_memory && !w_misaligned;
            instruction_writeback <= instruction_memory;
        end
    end

`ifdef MEMORY_MISALIGN_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset || mem_stall) begin
            misaligned_fault_writeback <= 1'b0;
        end else begin
            misaligned_fault_writeback <= w_misaligned;
        end
    end
`endif

endmodule
`default_nettype wire
